// File: rtl/fabric_config_pkg.sv
// Shared constants and state encoding for the fabric bitstream loader.
package fabric_config_pkg;

    localparam logic [31:0] BITSTREAM_START = 32'hFAB0FAB1;
    localparam int          DESYNC_FLAG     = 20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_HEADER,
        S_DATA
    } state_t;

    function automatic logic is_desync(input logic [31:0] word);
        return word[DESYNC_FLAG];
    endfunction

endpackage

// File: rtl/bitstream_fetch.sv
// Word fetcher: address counter plus a single-outstanding req/gnt/rvalid tracker.
module bitstream_fetch #(
    parameter int AddrWidth = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 launch_i,
    input  logic [AddrWidth-1:0] base_addr_i,
    input  logic                 fetch_en_i,
    output logic                 mem_req_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [31:0]          mem_rdata_i,
    output logic                 word_valid_o,
    output logic [31:0]          word_data_o
);

    logic [AddrWidth-1:0] addr_q;
    logic                 outstanding_q;
    logic                 granted;

    assign mem_req_o    = fetch_en_i && !outstanding_q;
    assign mem_addr_o   = addr_q;
    assign granted      = mem_req_o && mem_gnt_i;
    // Responses with nothing in flight (e.g. a late one after reset) are dropped here.
    assign word_valid_o = mem_rvalid_i && outstanding_q;
    assign word_data_o  = mem_rdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q        <= '0;
            outstanding_q <= 1'b0;
        end else begin
            if (launch_i) begin
                addr_q <= base_addr_i;
            end else if (granted) begin
                addr_q <= addr_q + AddrWidth'(1);
            end

            if (granted) begin
                outstanding_q <= 1'b1;
            end else if (word_valid_o) begin
                outstanding_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bitstream_loader.sv
// Replays a framed bitstream from word memory onto the fabric configuration port.
// state    | meaning
// S_IDLE   | waiting for start
// S_SYNC   | fetching the sync word
// S_HEADER | fetching a frame header
// S_DATA   | fetching the NumRows data words of a frame
module bitstream_loader
    import fabric_config_pkg::*;
#(
    parameter int NumRows   = 18,
    parameter int AddrWidth = 16,
    parameter int MaxWords  = 4096
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [AddrWidth-1:0]          base_addr_i,
    output logic                          mem_req_o,
    output logic [AddrWidth-1:0]          mem_addr_o,
    input  logic                          mem_gnt_i,
    input  logic                          mem_rvalid_i,
    input  logic [31:0]                   mem_rdata_i,
    output logic [31:0]                   bitstream_data_o,
    output logic                          bitstream_valid_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          error_o,
    output logic [$clog2(MaxWords+1)-1:0] words_sent_o
);

    localparam int CntWidth = $clog2(MaxWords + 1);
    localparam int RowWidth = $clog2(NumRows + 2);

    state_t              state_q, state_d;
    logic [RowWidth-1:0] rows_q, rows_d;
    logic [CntWidth-1:0] words_q, words_d;
    logic [31:0]         data_q, data_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                holdoff_q, holdoff_d;
    logic                launch;
    logic                busy;
    logic                forward;
    logic                word_valid;
    logic [31:0]         word_data;

    assign busy   = (state_q != S_IDLE);
    // holdoff_q blocks a start in the very cycle busy drops.
    assign launch = !busy && start_i && !holdoff_q;

    bitstream_fetch #(
        .AddrWidth(AddrWidth)
    ) u_fetch (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .launch_i    (launch),
        .base_addr_i (base_addr_i),
        .fetch_en_i  (busy),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .word_valid_o(word_valid),
        .word_data_o (word_data)
    );

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        words_d = words_q;
        data_d  = data_q;
        valid_d = 1'b0;
        done_d  = done_q;
        error_d = error_q;
        forward = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d = S_SYNC;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    words_d = '0;
                end
            end
            S_SYNC: begin
                if (word_valid) begin
                    if (word_data == BITSTREAM_START) begin
                        forward = 1'b1;
                        state_d = S_HEADER;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_HEADER: begin
                if (word_valid) begin
                    forward = 1'b1;
                    if (is_desync(word_data)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rows_d  = RowWidth'(NumRows);
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_valid) begin
                    forward = 1'b1;
                    rows_d  = rows_q - RowWidth'(1);
                    if (rows_q == RowWidth'(1)) begin
                        state_d = S_HEADER;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (forward) begin
            valid_d = 1'b1;
            data_d  = word_data;
            words_d = words_q + CntWidth'(1);
            // done_d is only set here by a desync header, which is allowed to land on the limit.
            if (words_d == CntWidth'(MaxWords) && !done_d) begin
                error_d = 1'b1;
                state_d = S_IDLE;
            end
        end

        holdoff_d = busy && (state_d == S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            rows_q    <= '0;
            words_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            holdoff_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            words_q   <= words_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            error_q   <= error_d;
            holdoff_q <= holdoff_d;
        end
    end

    assign bitstream_data_o  = data_q;
    assign bitstream_valid_o = valid_q;
    assign busy_o            = busy;
    assign done_o            = done_q;
    assign error_o           = error_q;
    assign words_sent_o      = words_q;

endmodule

// File: tb/tb_bitstream_loader.sv
// Directed and randomized loads against a framing-level reference model.
module tb_bitstream_loader;
    import fabric_config_pkg::*;

    localparam int NumRows   = 18;
    localparam int AddrWidth = 16;
    localparam int MaxWords  = 40;
    localparam int CntWidth  = $clog2(MaxWords + 1);
    localparam logic [31:0] DESYNC_WORD = 32'h0010_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 start;
    logic [15:0]          base_addr;
    logic                 mem_req;
    logic [15:0]          mem_addr;
    logic                 mem_gnt;
    logic                 mem_rvalid;
    logic [31:0]          mem_rdata;
    logic [31:0]          bs_data;
    logic                 bs_valid;
    logic                 busy;
    logic                 done;
    logic                 error;
    logic [CntWidth-1:0]  words_sent;

    bitstream_loader #(
        .NumRows  (NumRows),
        .AddrWidth(AddrWidth),
        .MaxWords (MaxWords)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .base_addr_i      (base_addr),
        .mem_req_o        (mem_req),
        .mem_addr_o       (mem_addr),
        .mem_gnt_i        (mem_gnt),
        .mem_rvalid_i     (mem_rvalid),
        .mem_rdata_i      (mem_rdata),
        .bitstream_data_o (bs_data),
        .bitstream_valid_o(bs_valid),
        .busy_o           (busy),
        .done_o           (done),
        .error_o          (error),
        .words_sent_o     (words_sent)
    );

    logic [31:0] mem [65536];

    // responder configuration (main process) and state (responder process)
    int          lat_cfg    = 1;
    int          stall_cfg  = 0;
    bit          stall_rand = 0;
    int          lat_left   = 0;
    int          cur_stall  = -1;
    logic [15:0] gaddr      = '0;
    logic [15:0] req_log [$];

    // monitor state
    int          cyc = 0;
    int          last_pulse_cyc = 0;
    int          fall_cyc = 0;
    int          n_unstable = 0;
    int          n_overlap = 0;
    int          n_orphan = 0;
    int          n_rvalid = 0;
    logic [31:0] got_q [$];
    bit          tb_out = 0;
    bit          prev_rv_ok = 0;
    bit          prev_req = 0;
    bit          prev_gnt = 0;
    bit          prev_rst = 1;
    bit          prev_busy = 0;
    logic [15:0] prev_addr = '0;

    // expectation / bookkeeping
    logic [31:0] exp_q [$];
    int          exp_done, exp_err, exp_nreq;
    int          got_n0, req_n0, unst0, ovl0, orph0, start_cyc;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial begin
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata = $urandom;
            if (lat_left > 0) begin
                lat_left--;
                if (lat_left == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = mem[gaddr];
                end
            end else if (mem_req) begin
                if (cur_stall < 0)
                    cur_stall = stall_rand ? int'($urandom_range(stall_cfg, 0)) : stall_cfg;
                if (cur_stall == 0) begin
                    mem_gnt = 1'b1;
                    gaddr = mem_addr;
                    req_log.push_back(mem_addr);
                    lat_left = lat_cfg;
                    cur_stall = -1;
                end else begin
                    cur_stall--;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bs_valid) begin
                got_q.push_back(bs_data);
                last_pulse_cyc = cyc;
                if (!prev_rv_ok) n_orphan++;
            end
            if (prev_busy && !busy) fall_cyc = cyc;
            if (prev_req && !prev_gnt && !prev_rst && (!mem_req || mem_addr !== prev_addr))
                n_unstable++;
            if (mem_req && tb_out) n_overlap++;
            if (mem_rvalid) n_rvalid++;
            prev_rv_ok = mem_rvalid && tb_out && !rst;
            if (rst) tb_out = 0;
            else if (mem_req && mem_gnt) tb_out = 1;
            else if (mem_rvalid) tb_out = 0;
            prev_req = mem_req;
            prev_gnt = mem_gnt;
            prev_rst = rst;
            prev_addr = mem_addr;
            prev_busy = busy;
        end
    end

    // Walks the framing in memory: sync, then header (+NumRows data unless desync), capped at MaxWords.
    task automatic model(input logic [15:0] base);
        logic [15:0] a;
        logic [31:0] w;
        exp_q.delete();
        exp_done = 0;
        exp_err = 0;
        a = base;
        if (mem[a] !== BITSTREAM_START) begin
            exp_err = 1;
            exp_nreq = 1;
            return;
        end
        exp_q.push_back(mem[a]);
        a++;
        while (exp_done == 0 && exp_err == 0) begin
            w = mem[a];
            a++;
            exp_q.push_back(w);
            if (w[DESYNC_FLAG]) begin
                exp_done = 1;
            end else begin
                for (int i = 0; i < NumRows && exp_q.size() < MaxWords; i++) begin
                    exp_q.push_back(mem[a]);
                    a++;
                end
            end
            if (exp_done == 0 && exp_q.size() == MaxWords) exp_err = 1;
        end
        exp_nreq = exp_q.size();
    endtask

    task automatic put_load(input logic [15:0] base, input int nframes);
        logic [15:0] a;
        logic [31:0] w;
        a = base;
        mem[a] = BITSTREAM_START;
        a++;
        for (int f = 0; f < nframes; f++) begin
            w = $urandom;
            w[DESYNC_FLAG] = 1'b0;
            mem[a] = w;
            a++;
            for (int i = 0; i < NumRows; i++) begin
                mem[a] = $urandom;
                a++;
            end
        end
        mem[a] = $urandom | DESYNC_WORD;
    endtask

    task automatic prep_load(input logic [15:0] base);
        model(base);
        got_n0 = got_q.size();
        req_n0 = req_log.size();
        unst0 = n_unstable;
        ovl0 = n_overlap;
        orph0 = n_orphan;
    endtask

    task automatic start_load(input string tag, input logic [15:0] base);
        prep_load(base);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = base;
        @(posedge clk);
        #1;
        start = 1'b0;
        base_addr = $urandom;
        start_cyc = cyc;
        chk({tag, "_req_t1"}, 32'({mem_req, mem_addr}), 32'({1'b1, base}));
    endtask

    task automatic finish_load(input string tag, input logic [15:0] base);
        int k;
        int n;
        logic [15:0] ea;
        k = 0;
        while (busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        #1;
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        n = got_q.size() - got_n0;
        chk({tag, "_pulses"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++)
            chk({tag, "_word"}, got_q[got_n0 + i], exp_q[i]);
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_error"}, 32'(error), 32'(exp_err));
        chk({tag, "_words_sent"}, 32'(words_sent), 32'(exp_q.size()));
        chk({tag, "_nreq"}, 32'(req_log.size() - req_n0), 32'(exp_nreq));
        for (int i = 0; i < exp_nreq && req_n0 + i < req_log.size(); i++) begin
            ea = base + 16'(i);
            chk({tag, "_addr"}, 32'(req_log[req_n0 + i]), 32'(ea));
        end
        if (exp_q.size() > 0)
            chk({tag, "_fall_with_last"}, 32'(fall_cyc), 32'(last_pulse_cyc));
        if (!stall_rand)
            chk({tag, "_cycles"}, 32'(fall_cyc - start_cyc),
                32'(exp_nreq * (1 + stall_cfg + lat_cfg) + 1));
        chk({tag, "_req_stable"}, 32'(n_unstable - unst0), 32'd0);
        chk({tag, "_one_outstanding"}, 32'(n_overlap - ovl0), 32'd0);
        chk({tag, "_pulse_after_rvalid"}, 32'(n_orphan - orph0), 32'd0);
    endtask

    initial begin
        int k;
        int g;
        int rv0;
        logic [15:0] b;
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ctrl", 32'({mem_req, bs_valid, busy, done, error}), 32'd0);
        chk("reset_addr", 32'(mem_addr), 32'd0);
        chk("reset_data", bs_data, 32'd0);
        chk("reset_words", 32'(words_sent), 32'd0);

        mem[16'h0100] = BITSTREAM_START;
        mem[16'h0101] = DESYNC_WORD;
        start_load("minimal", 16'h0100);
        finish_load("minimal", 16'h0100);
        chk("minimal_words_const", 32'(words_sent), 32'd2);
        chk("minimal_done_const", 32'(done), 32'd1);

        mem[16'h0010] = BITSTREAM_START;
        mem[16'h0011] = 32'h0800_0001;
        for (int i = 0; i < NumRows; i++) mem[16'h0012 + i] = $urandom;
        mem[16'h0024] = DESYNC_WORD;
        start_load("frame", 16'h0010);
        finish_load("frame", 16'h0010);
        chk("frame_pulses_const", 32'(got_q.size() - got_n0), 32'd21);
        chk("frame_last_addr", 32'(req_log[req_log.size() - 1]), 32'h0024);

        mem[16'h0200] = 32'hDEAD_BEEF;
        start_load("bad_sync", 16'h0200);
        finish_load("bad_sync", 16'h0200);
        chk("bad_sync_error_const", 32'({error, busy, done}), 32'b100);

        put_load(16'h0300, 3);
        start_load("limit", 16'h0300);
        finish_load("limit", 16'h0300);
        chk("limit_words_const", 32'(words_sent), 32'(MaxWords));
        chk("limit_flags_const", 32'({error, done}), 32'b10);

        put_load(16'h0600, 2);
        start_load("limit_desync", 16'h0600);
        finish_load("limit_desync", 16'h0600);
        chk("limit_desync_flags", 32'({error, done, words_sent}), 32'({2'b01, CntWidth'(MaxWords)}));

        stall_cfg = 5;
        mem[16'hFFFF] = BITSTREAM_START;
        mem[16'h0000] = DESYNC_WORD;
        start_load("stall_wrap", 16'hFFFF);
        finish_load("stall_wrap", 16'hFFFF);
        chk("stall_wrap_second_addr", 32'(req_log[req_log.size() - 1]), 32'h0000);
        stall_cfg = 0;

        // start in the falling cycle is ignored; one cycle later it is taken
        start = 1'b1;
        base_addr = 16'h0100;
        prep_load(16'h0100);
        @(posedge clk);
        #1;
        chk("holdoff_ignored", 32'({busy, mem_req}), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        start_cyc = cyc;
        chk("holdoff_next_taken", 32'({busy, mem_req, mem_addr}), 32'({2'b11, 16'h0100}));
        finish_load("holdoff", 16'h0100);

        lat_cfg = 8;
        put_load(16'h0400, 1);
        start_load("rst_mid", 16'h0400);
        k = 0;
        while (!((got_q.size() - got_n0) >= 4 && lat_left == 8) && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("rst_mid_reach_data", 32'(k < 2000), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        g = got_q.size();
        rv0 = n_rvalid;
        chk("rst_mid_ctrl", 32'({mem_req, bs_valid, busy, done, error}), 32'd0);
        chk("rst_mid_addr", 32'(mem_addr), 32'd0);
        chk("rst_mid_data", bs_data, 32'd0);
        chk("rst_mid_words", 32'(words_sent), 32'd0);
        repeat (12) @(negedge clk);
        #1;
        chk("rst_mid_late_rvalid_seen", 32'(n_rvalid > rv0), 32'd1);
        chk("rst_mid_no_pulse", 32'(got_q.size() - g), 32'd0);
        chk("rst_mid_idle", 32'({busy, mem_req}), 32'd0);
        lat_cfg = 1;
        mem[16'h0500] = BITSTREAM_START;
        mem[16'h0501] = DESYNC_WORD;
        start_load("after_rst", 16'h0500);
        finish_load("after_rst", 16'h0500);

        stall_rand = 1;
        for (int it = 0; it < 8; it++) begin
            b = 16'($urandom);
            put_load(b, int'($urandom_range(3, 0)));
            if ($urandom_range(5, 0) == 0) mem[b] = BITSTREAM_START ^ (32'h1 << $urandom_range(31, 0));
            stall_cfg = int'($urandom_range(3, 0));
            lat_cfg = int'($urandom_range(3, 1));
            start_load("random", b);
            finish_load("random", b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitstream_loader.md
# bitstream_loader

Bitstream source for the fabric configuration port. On a start pulse it fetches 32-bit bitstream words from a word-addressed memory, starting at a given base address, and replays them one word per valid pulse onto the fabric configuration block's `bitstream_data`/`bitstream_valid` input. It parses the same framing as the receiver: sync word, then headers, each followed by NumRows data words. It stops after forwarding the desync header, or flags an error.

## Interface
- NumRows, 18: data words following each non-desync header
- AddrWidth, 16: memory word-address width
- MaxWords, 4096: forwarded-word limit per load, sync word included
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  begin a load; ignored while busy_o
- base_addr_i  in  AddrWidth  first word address, sampled with start_i
- mem_req_o  out  1  read request, held until granted
- mem_addr_o  out  AddrWidth  word address, stable while mem_req_o
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid (≥1 cycle after grant)
- mem_rdata_i  in  32  read data
- bitstream_data_o  out  32  word to fabric configuration block
- bitstream_valid_o  out  1  one-cycle pulse per forwarded word
- busy_o  out  1  load in progress
- done_o  out  1  sticky: last load ended with desync header
- error_o  out  1  sticky: last load aborted
- words_sent_o  out  $clog2(MaxWords+1)  words forwarded in current/last load

## Operation
- Reset values: all outputs 0; state S_IDLE.
- States:
  - S_IDLE → S_SYNC on start_i. Latch base_addr_i; clear done_o, error_o and words_sent_o.
  - S_SYNC: fetch one word.
    - If it equals 32'hFAB0FAB1: forward it and go to S_HEADER.
    - Otherwise: do not forward it, set error_o and go to S_IDLE.
  - S_HEADER: fetch and forward one word.
    - If bit 20 (DESYNC_FLAG) is set: set done_o and go to S_IDLE.
    - Otherwise: load the row counter with NumRows and go to S_DATA.
  - S_DATA: fetch and forward words, decrementing the row counter. When it reaches 0, go to S_HEADER.
- Memory handshake: at most one outstanding request.
  - mem_req_o stays asserted, with mem_addr_o constant, until mem_gnt_i.
  - No new request is issued until the matching mem_rvalid_i.
  - mem_rvalid_i with no request outstanding is ignored.
- Address increments by 1 per granted request and wraps modulo 2^AddrWidth without error.
- words_sent_o increments on every bitstream_valid_o pulse.
- Word limit: if words_sent_o reaches MaxWords and the word just forwarded was not a desync header, set error_o and go to S_IDLE.
- On error the downstream receiver may be left mid-frame. The next successful load's sync word is ignored by the receiver only if it is in S_DATA; software must reset the fabric configuration block after error_o.
- busy_o = (state != S_IDLE).

## Timing
- start_i sampled at cycle t → mem_req_o high with mem_addr_o = base_addr_i at t+1.
- mem_rvalid_i at cycle r → bitstream_valid_o and bitstream_data_o (registered) at r+1. The next mem_req_o is also asserted at r+1.
- With gnt in the request cycle and rvalid one cycle later, throughput is one word per 2 cycles.
- Final word: done_o (or error_o) rises and busy_o falls in the same cycle as that word's bitstream_valid_o pulse. The bad-sync error has no pulse; error_o rises at r+1.
- start_i in the same cycle busy_o falls is ignored; start_i on the following cycle is accepted.
- rst_i mid-load: all outputs 0 on the next cycle and any outstanding response is discarded. A start_i after reset deasserts behaves normally.

## Structure
- Package fabric_config_pkg:
  - BITSTREAM_START = 32'hFAB0FAB1
  - DESYNC_FLAG = 20
  - state_t typedef {S_IDLE, S_SYNC, S_HEADER, S_DATA}
- One sub-module, bitstream_fetch. It owns the address counter, the req/gnt/rvalid tracking and the outstanding flag. It presents a word-valid strobe plus data to the parser FSM in bitstream_loader.

## Test plan
- Minimal load: memory holds FAB0FAB1, 00100000 → two pulses with those words, done_o=1, words_sent_o=2, error_o=0.
- One frame: FAB0FAB1, 08000001, 18 data words, 00100000 at base 0x0010 → 21 pulses in order; addresses 0x0010..0x0024; done_o=1.
- Bad sync: first word DEADBEEF → no bitstream_valid_o pulse, error_o=1, busy_o=0, one memory request issued.
- Word limit: MaxWords=8, sync followed by non-desync frames → exactly 8 pulses, then error_o=1, done_o=0.
- Stalls and wrap: hold mem_gnt_i low 5 cycles, base 0xFFFF → mem_req_o and mem_addr_o stable during stall, second address 0x0000; no output pulse during stall.
- Reset mid-S_DATA: assert rst_i, deliver a late mem_rvalid_i → all outputs 0, no pulse; a following start_i completes the minimal load correctly.
